// File: rtl/ps2_pkg.sv
// Shared constants, field indices and FSM state type for the PS/2 set-2 scancode encoder.
package ps2_pkg;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_PAUSE  = 8'hE1;
   localparam logic [7:0] SC_BAT    = 8'hAA;
   localparam logic [7:0] SC_ACK    = 8'hFA;
   localparam logic [7:0] SC_RESEND = 8'hFE;
   localparam logic [7:0] SC_ECHO   = 8'hEE;
   localparam logic [7:0] SC_ERR0   = 8'h00;
   localparam logic [7:0] SC_ERR1   = 8'hFF;

   localparam logic [7:0] SC_FAKE_SHIFT_L = 8'h12;
   localparam logic [7:0] SC_FAKE_SHIFT_R = 8'h59;
   localparam logic [7:0] SC_PAUSE_CODE   = 8'h77;

   localparam int KEY_TOGGLE  = 10;
   localparam int KEY_PRESSED = 9;
   localparam int KEY_EXT     = 8;

   // Pause is E1 followed by seven more bytes; the counter indexes those seven.
   localparam logic [2:0] PAUSE_LAST = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_PAUSE
   } ps2_state_e;

   function automatic logic is_prefix(input logic [7:0] b);
      return (b == SC_EXT) || (b == SC_BRK) || (b == SC_PAUSE);
   endfunction

   function automatic logic is_fake_shift(input logic [7:0] b);
      return (b == SC_FAKE_SHIFT_L) || (b == SC_FAKE_SHIFT_R);
   endfunction

   function automatic logic [KEY_PRESSED:0] make_key(input logic pressed, input logic ext,
                                                     input logic [7:0] code);
      return {pressed, ext, code};
   endfunction

endpackage

// File: rtl/ps2_seq_timer.sv
// Saturating idle counter: cleared by every received byte, flags a stalled prefix sequence.
module ps2_seq_timer #(
   parameter logic [23:0] TIMEOUT = 24'd3_000_000
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic clear,
   output logic expired
);

   logic [23:0] r_count;

   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (r_count != TIMEOUT) begin
         r_count <= r_count + 24'd1;
      end
   end

   assign expired = (r_count == TIMEOUT);

endmodule

// File: rtl/ps2_key_encoder.sv
// Turns the raw PS/2 set-2 byte stream into the 11-bit toggle-format ps2_key event word,
// handling E0/F0/E1 prefixes, housekeeping bytes, fake shifts and stalled sequences.
module ps2_key_encoder
   import ps2_pkg::*;
#(
   parameter logic [23:0] TIMEOUT = 24'd3_000_000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [7:0]  kbd_data,
   input  logic        kbd_valid,
   output logic [10:0] ps2_key,
   output logic        key_event,
   output logic        kbd_err
);

   ps2_state_e r_state, w_next_state;
   logic       r_ext, w_next_ext;
   logic [2:0] r_pcnt, w_next_pcnt;
   logic [10:0] r_key;
   logic       r_key_event, r_err;

   logic       w_emit, w_err, w_idle_dispatch, w_expired;
   logic [9:0] w_val;

   ps2_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk_sys (clk_sys),
      .reset   (reset),
      .clear   (kbd_valid),
      .expired (w_expired)
   );

   // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
   always_comb begin
      w_next_state    = r_state;
      w_next_ext      = r_ext;
      w_next_pcnt     = r_pcnt;
      w_emit          = 1'b0;
      w_val           = r_key[9:0];
      w_err           = 1'b0;
      w_idle_dispatch = 1'b0;

      if (kbd_valid) begin
         unique case (r_state)
            ST_IDLE: w_idle_dispatch = 1'b1;
            ST_EXT: begin
               if (kbd_data == SC_BRK) begin
                  w_next_state = ST_BRK;
                  w_next_ext   = 1'b1;
               end else if (is_fake_shift(kbd_data)) begin
                  w_next_state = ST_IDLE;
                  w_next_ext   = 1'b0;
               end else if (kbd_data != SC_EXT) begin
                  w_emit       = 1'b1;
                  w_val        = make_key(1'b1, 1'b1, kbd_data);
                  w_next_state = ST_IDLE;
                  w_next_ext   = 1'b0;
               end
            end
            ST_BRK: begin
               if (is_prefix(kbd_data)) begin
                  // A prefix where a code was expected: flag it and restart on this byte.
                  w_err           = 1'b1;
                  w_idle_dispatch = 1'b1;
               end else begin
                  w_emit       = !(r_ext && is_fake_shift(kbd_data));
                  w_val        = make_key(1'b0, r_ext, kbd_data);
                  w_next_state = ST_IDLE;
                  w_next_ext   = 1'b0;
               end
            end
            ST_PAUSE: begin
               if (r_pcnt == PAUSE_LAST) begin
                  w_emit       = 1'b1;
                  w_val        = make_key(1'b1, 1'b1, SC_PAUSE_CODE);
                  w_next_state = ST_IDLE;
               end else begin
                  w_next_pcnt = r_pcnt + 3'd1;
               end
            end
            default: w_next_state = ST_IDLE;
         endcase

         if (w_idle_dispatch) begin
            w_next_state = ST_IDLE;
            w_next_ext   = 1'b0;
            case (kbd_data)
               SC_EXT: begin
                  w_next_state = ST_EXT;
                  w_next_ext   = 1'b1;
               end
               SC_BRK:   w_next_state = ST_BRK;
               SC_PAUSE: begin
                  w_next_state = ST_PAUSE;
                  w_next_pcnt  = 3'd0;
               end
               SC_BAT, SC_ACK, SC_RESEND, SC_ECHO: ;
               SC_ERR0, SC_ERR1: w_err = 1'b1;
               default: begin
                  w_emit = 1'b1;
                  w_val  = make_key(1'b1, 1'b0, kbd_data);
               end
            endcase
         end
      end else if (w_expired && (r_state != ST_IDLE)) begin
         w_next_state = ST_IDLE;
         w_next_ext   = 1'b0;
         w_err        = 1'b1;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_ext       <= 1'b0;
         r_pcnt      <= 3'd0;
         r_key       <= '0;
         r_key_event <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_ext       <= w_next_ext;
         r_pcnt      <= w_next_pcnt;
         r_key_event <= w_emit;
         r_err       <= w_err;
         if (w_emit) begin
            r_key <= {~r_key[KEY_TOGGLE], w_val};
         end
      end
   end

   assign ps2_key   = r_key;
   assign key_event = r_key_event;
   assign kbd_err   = r_err;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Randomised scoreboard bench for ps2_key_encoder against a prefix-context reference model.
module tb_ps2_key_encoder;

   localparam logic [23:0] TMO   = 24'd100;
   localparam int          TMO_I = 100;

   logic        clk_sys   = 1'b0;
   logic        reset     = 1'b1;
   logic        kbd_valid = 1'b0;
   logic [7:0]  kbd_data  = 8'h00;
   logic [10:0] ps2_key;
   logic        key_event;
   logic        kbd_err;

   always #5 clk_sys = ~clk_sys;

   ps2_key_encoder #(.TIMEOUT(TMO)) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .kbd_data  (kbd_data),
      .kbd_valid (kbd_valid),
      .ps2_key   (ps2_key),
      .key_event (key_event),
      .kbd_err   (kbd_err)
   );

   typedef struct {
      logic [9:0] key;
      int         cyc;
   } ev_t;

   ev_t  exp_ev[$];
   int   exp_err[$];
   int   checks  = 0;
   int   errors  = 0;
   int   cyc     = 0;
   logic exp_tog = 1'b0;

   // Reference context: pending E0 / F0 flags and remaining Pause bytes.
   bit m_ext, m_brk;
   int m_pause;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic push_ev(input logic [9:0] k, input int c);
      ev_t e;
      e.key = k;
      e.cyc = c;
      exp_ev.push_back(e);
   endtask

   task automatic model_clear();
      m_ext   = 0;
      m_brk   = 0;
      m_pause = 0;
   endtask

   task automatic model_byte(input logic [7:0] b, input int c);
      bit fake, pfx;
      fake = (b == 8'h12) || (b == 8'h59);
      pfx  = (b == 8'hE0) || (b == 8'hF0) || (b == 8'hE1);
      if (m_pause > 0) begin
         m_pause--;
         if (m_pause == 0) push_ev(10'h377, c);
         return;
      end
      if (m_brk) begin
         if (pfx) begin
            exp_err.push_back(c);
            model_clear();
         end else begin
            if (!(m_ext && fake)) push_ev({1'b0, m_ext, b}, c);
            model_clear();
            return;
         end
      end else if (m_ext) begin
         if (b == 8'hF0) m_brk = 1;
         else if (fake) m_ext = 0;
         else if (b != 8'hE0) begin
            push_ev({2'b11, b}, c);
            m_ext = 0;
         end
         return;
      end
      case (b)
         8'hE0: m_ext = 1;
         8'hF0: m_brk = 1;
         8'hE1: m_pause = 7;
         8'hAA, 8'hFA, 8'hFE, 8'hEE: ;
         8'h00, 8'hFF: exp_err.push_back(c);
         default: push_ev({2'b10, b}, c);
      endcase
   endtask

   // Byte strobe followed by 'gap' cycles until the next strobe may start (gap >= 2).
   task automatic send(input logic [7:0] b, input int gap);
      int c;
      @(negedge clk_sys);
      kbd_data  = b;
      kbd_valid = 1'b1;
      c = cyc + 1;
      model_byte(b, c);
      if (gap >= TMO_I + 2 && (m_ext || m_brk || m_pause > 0)) begin
         exp_err.push_back(c + TMO_I + 1);
         model_clear();
      end
      @(negedge clk_sys);
      kbd_valid = 1'b0;
      repeat (gap - 2) @(negedge clk_sys);
   endtask

   task automatic send_seq(input logic [7:0] bytes[$]);
      foreach (bytes[i]) send(bytes[i], 3);
   endtask

   function automatic logic [7:0] pick_byte();
      int r;
      r = $urandom_range(0, 99);
      if (r < 12) return 8'hE0;
      if (r < 22) return 8'hF0;
      if (r < 26) return 8'hE1;
      if (r < 34) return ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
      if (r < 40) begin
         case ($urandom_range(0, 5))
            0: return 8'hAA;
            1: return 8'hFA;
            2: return 8'hFE;
            3: return 8'hEE;
            4: return 8'h00;
            default: return 8'hFF;
         endcase
      end
      return 8'($urandom_range(0, 255));
   endfunction

   always @(posedge clk_sys) begin
      cyc = cyc + 1;
      #1;
      if (reset) exp_tog = 1'b0;
      if (key_event) begin
         if (exp_ev.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual=%h required=none", ps2_key);
         end else begin
            ev_t e;
            e = exp_ev.pop_front();
            exp_tog = ~exp_tog;
            check("event_key", 32'(ps2_key[9:0]), 32'(e.key));
            check("event_toggle", 32'(ps2_key[10]), 32'(exp_tog));
            check("event_cycle", cyc, e.cyc);
         end
      end
      if (kbd_err) begin
         if (exp_err.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_err actual=1 required=0 at cycle %0d", cyc);
         end else begin
            check("err_cycle", cyc, exp_err.pop_front());
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_clear();
      repeat (4) @(negedge clk_sys);
      check("reset_key", 32'(ps2_key), 32'h0);
      check("reset_event", 32'(key_event), 32'h0);
      check("reset_err", 32'(kbd_err), 32'h0);
      reset = 1'b0;
      repeat (2) @(negedge clk_sys);

      send_seq('{8'h1C, 8'hF0, 8'h1C});
      send_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75});
      send_seq('{8'hE0, 8'h12, 8'hE0, 8'h7C});
      send_seq('{8'hE0, 8'hF0, 8'h7C, 8'hE0, 8'hF0, 8'h12});
      send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77});
      send_seq('{8'hAA, 8'hFA, 8'hFF});
      send_seq('{8'hF0, 8'hE0, 8'h6B});
      send(8'hE0, TMO_I + 20);
      send(8'h29, 4);

      // Reset mid-sequence, with a byte strobed in the same cycle as reset.
      send(8'hE0, 3);
      @(negedge clk_sys);
      reset     = 1'b1;
      kbd_data  = 8'h1C;
      kbd_valid = 1'b1;
      model_clear();
      @(negedge clk_sys);
      kbd_valid = 1'b0;
      @(negedge clk_sys);
      check("midreset_key", 32'(ps2_key), 32'h0);
      check("midreset_event", 32'(key_event), 32'h0);
      reset = 1'b0;
      @(negedge clk_sys);
      send(8'h75, 4);

      for (int i = 0; i < 400; i++) begin
         int gap;
         gap = ($urandom_range(0, 19) == 0) ? TMO_I + 20 + int'($urandom_range(0, 30))
                                            : int'($urandom_range(2, 6));
         send(pick_byte(), gap);
      end

      send(8'h1C, TMO_I + 20);
      repeat (10) @(negedge clk_sys);
      check("pending_events", exp_ev.size(), 0);
      check("pending_errs", exp_err.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
